// File: rtl/modexp_ctrl.sv
// modexp_ctrl: left-to-right square-and-multiply sequencer (Montgomery domain).
// Computes result = x^e mod m by chaining operations on an external Montgomery
// multiplier that returns a*b*R^-1 mod m.
//
// Multiplier handshake (initiator side): mul_start is a one-cycle pulse issued
// from an issue state; mul_a/mul_b/mul_m are valid in that cycle and held
// stable through the following WAIT state until mul_done is sampled high.
// mul_done is only honoured in a WAIT state, where mul_result is captured on
// the same edge; in any other state it is ignored.
module modexp_ctrl #(
  parameter int WIDTH  = 512,
  parameter int EWIDTH = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  in_x,
  input  logic [EWIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]  in_m,
  input  logic [WIDTH-1:0]  in_r,
  input  logic [WIDTH-1:0]  in_r2,
  output logic [WIDTH-1:0]  result,
  output logic              done,
  output logic              mul_start,
  output logic [WIDTH-1:0]  mul_a,
  output logic [WIDTH-1:0]  mul_b,
  output logic [WIDTH-1:0]  mul_m,
  input  logic [WIDTH-1:0]  mul_result,
  input  logic              mul_done,
  output logic [3:0]        state_dbg
);

  localparam int IW = (EWIDTH > 1) ? $clog2(EWIDTH) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(EWIDTH - 1);

  // IDLE is encoded as zero so a debug probe reads 0 after reset.
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_XM    = 4'd1,
    S_XM_W  = 4'd2,
    S_SQ    = 4'd3,
    S_SQ_W  = 4'd4,
    S_MUL   = 4'd5,
    S_MUL_W = 4'd6,
    S_NEXT  = 4'd7,
    S_OUT   = 4'd8,
    S_OUT_W = 4'd9,
    S_DONE  = 4'd10
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [WIDTH-1:0]  x_reg;
  logic [EWIDTH-1:0] e_reg;
  logic [WIDTH-1:0]  m_reg;
  logic [WIDTH-1:0]  r_reg;
  logic [WIDTH-1:0]  r2_reg;
  logic [WIDTH-1:0]  xm;
  logic [WIDTH-1:0]  acc;
  logic [IW-1:0]     idx;

  assign state_dbg = state;
  assign mul_m     = m_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Operand latching, product capture and exponent bit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg  <= '0;
      e_reg  <= '0;
      m_reg  <= '0;
      r_reg  <= '0;
      r2_reg <= '0;
      xm     <= '0;
      acc    <= '0;
      result <= '0;
      idx    <= IDX_TOP;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x_reg  <= in_x;
            e_reg  <= in_e;
            m_reg  <= in_m;
            r_reg  <= in_r;
            r2_reg <= in_r2;
            idx    <= IDX_TOP;
          end
        end
        S_XM_W: begin
          // x*R^2*R^-1 = x in Montgomery form; acc starts as Montgomery 1.
          if (mul_done) begin
            xm  <= mul_result;
            acc <= r_reg;
          end
        end
        S_SQ_W, S_MUL_W: begin
          if (mul_done) acc <= mul_result;
        end
        S_NEXT: begin
          if (idx != '0) idx <= idx - IW'(1);
        end
        S_OUT_W: begin
          if (mul_done) result <= mul_result;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic, start pulse, operand mux and completion pulse.
  always_comb begin
    state_nx  = state;
    mul_start = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_XM;
      end
      S_XM: begin
        mul_start = 1'b1;
        mul_a     = x_reg;
        mul_b     = r2_reg;
        state_nx  = S_XM_W;
      end
      S_XM_W: begin
        mul_a = x_reg;
        mul_b = r2_reg;
        if (mul_done) state_nx = S_SQ;
      end
      S_SQ: begin
        mul_start = 1'b1;
        mul_a     = acc;
        mul_b     = acc;
        state_nx  = S_SQ_W;
      end
      S_SQ_W: begin
        mul_a = acc;
        mul_b = acc;
        if (mul_done) state_nx = e_reg[idx] ? S_MUL : S_NEXT;
      end
      S_MUL: begin
        mul_start = 1'b1;
        mul_a     = acc;
        mul_b     = xm;
        state_nx  = S_MUL_W;
      end
      S_MUL_W: begin
        mul_a = acc;
        mul_b = xm;
        if (mul_done) state_nx = S_NEXT;
      end
      S_NEXT: begin
        state_nx = (idx == '0) ? S_OUT : S_SQ;
      end
      S_OUT: begin
        // Multiplying by plain 1 leaves the Montgomery domain.
        mul_start = 1'b1;
        mul_a     = acc;
        mul_b     = WIDTH'(1);
        state_nx  = S_OUT_W;
      end
      S_OUT_W: begin
        mul_a = acc;
        mul_b = WIDTH'(1);
        if (mul_done) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb_modexp_ctrl: directed and random jobs against a behavioural Montgomery
// multiplier and a plain-arithmetic modexp reference.
module tb_modexp_ctrl;

  localparam int W  = 16;
  localparam int EW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [W-1:0]  in_x = '0, in_m = '0, in_r = '0, in_r2 = '0;
  logic [EW-1:0] in_e = '0;
  logic [W-1:0]  result, mul_a, mul_b, mul_m, mul_result;
  logic          done, mul_start, mul_done;
  logic [3:0]    state_dbg;

  modexp_ctrl #(.WIDTH(W), .EWIDTH(EW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
    .result(result), .done(done),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
    .mul_result(mul_result), .mul_done(mul_done), .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;

  // Montgomery product a*b*R^-1 mod m with R = 2^W.
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] m);
    longint rm, k, p;
    if (m == 0) return '0;
    rm = (longint'(1) << W) % longint'(m);
    k  = 0;
    for (longint i = 1; i < longint'(m); i++)
      if ((rm * i) % longint'(m) == 1) k = i;
    p = (longint'(a) * longint'(b)) % longint'(m);
    return W'((p * k) % longint'(m));
  endfunction

  function automatic int ref_modexp(input int x, input int e, input int m);
    int r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * x) % m;
    return r;
  endfunction

  // behavioural multiplier with programmable latency
  int            lat = 5;
  logic          busy = 1'b0;
  int            cnt = 0;
  logic [W-1:0]  ha = '0, hb = '0, hm = '0;
  logic          mdl_done = 1'b0, mdl_done_d = 1'b0;
  logic [W-1:0]  mdl_res = '0;
  logic          inj_en = 1'b0;
  logic          inj_done;

  always @(posedge clk) begin
    mdl_done_d <= mdl_done;
    if (reset) begin
      busy <= 1'b0; cnt <= 0; mdl_done <= 1'b0;
    end else begin
      mdl_done <= 1'b0;
      if (mul_start) begin
        busy <= 1'b1; cnt <= lat; ha <= mul_a; hb <= mul_b; hm <= mul_m;
      end else if (busy) begin
        if (cnt == 1) begin
          mdl_done <= 1'b1; mdl_res <= mont(ha, hb, hm); busy <= 1'b0;
        end else cnt <= cnt - 1;
      end
    end
  end

  // Spurious done pulses land in issue states and in the cycle after a real done.
  assign inj_done   = inj_en & (mul_start | mdl_done_d);
  assign mul_done   = mdl_done | inj_done;
  assign mul_result = mdl_res;

  // operand stability monitor and pulse counters
  int stab_bad = 0;
  int n_start = 0;
  int n_done = 0;
  always @(negedge clk)
    if (busy && !reset && (mul_a !== ha || mul_b !== hb || mul_m !== hm))
      stab_bad <= stab_bad + 1;
  always @(posedge clk) begin
    if (!reset && mul_start) n_start <= n_start + 1;
    if (!reset && done)      n_done  <= n_done + 1;
  end

  // scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one complete job, optional mid-job restart and result-hold check
  task automatic run_job(input logic [W-1:0] x, input logic [EW-1:0] e,
                         input bit restart, input bit hold_en, input logic [W-1:0] hold_val);
    int exp_res, exp_n, s0, d0, cyc;
    exp_res = ref_modexp(int'(x), int'(e), 13);
    exp_n   = 2 + EW + $countones(e);
    @(negedge clk);
    in_x = x; in_e = e; in_m = 16'd13; in_r = 16'd3; in_r2 = 16'd9; start = 1'b1;
    s0 = n_start; d0 = n_done;
    @(negedge clk);
    start = 1'b0;
    in_x = W'($urandom); in_e = EW'($urandom); in_m = W'($urandom);
    in_r = W'($urandom); in_r2 = W'($urandom);
    cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      if (hold_en) chk("result_hold", 32'(result), 32'(hold_val));
      if (mul_start) chk("mul_m", 32'(mul_m), 32'd13);
      start = (restart && cyc == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    chk("result", 32'(result), 32'(exp_res));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("result_held", 32'(result), 32'(exp_res));
    repeat (20) @(negedge clk);
    chk("done_count", 32'(n_done - d0), 32'd1);
    chk("mul_count", 32'(n_start - s0), 32'(exp_n));
  endtask

  initial begin
    int s0, cyc;
    logic [W-1:0]  rx;
    logic [EW-1:0] re;

    // reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mul_start", 32'(mul_start), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    chk("rst_mul_m", 32'(mul_m), 32'd0);
    chk("rst_state_idle", 32'(state_dbg), 32'd0);
    reset = 1'b0;

    // directed jobs
    run_job(16'd7, 4'd5,  1'b0, 1'b0, '0);
    chk("x7e5", 32'(result), 32'h000B);
    run_job(16'd7, 4'd0,  1'b0, 1'b0, '0);
    chk("x7e0", 32'(result), 32'h0001);
    run_job(16'd7, 4'd15, 1'b0, 1'b0, '0);
    chk("x7e15", 32'(result), 32'h0005);
    run_job(16'd2, 4'd3,  1'b0, 1'b1, 16'h0005);
    chk("x2e3", 32'(result), 32'h0008);

    // restart during a wait plus spurious multiplier dones
    inj_en = 1'b1;
    run_job(16'd7, 4'd5, 1'b1, 1'b0, '0);
    inj_en = 1'b0;

    // reset during the third multiplier wait
    @(negedge clk);
    in_x = 16'd7; in_e = 4'd5; in_m = 16'd13; in_r = 16'd3; in_r2 = 16'd9; start = 1'b1;
    s0 = n_start;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (n_start - s0 < 3 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("third_issue_seen", 32'(n_start - s0), 32'd3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_state_idle", 32'(state_dbg), 32'd0);
    chk("midrst_mul_start", 32'(mul_start), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    repeat (10) @(negedge clk);
    chk("midrst_stays_idle", 32'(state_dbg), 32'd0);
    run_job(16'd7, 4'd5, 1'b0, 1'b0, '0);
    chk("after_rst_x7e5", 32'(result), 32'h000B);

    // single-cycle multiplier latency
    lat = 1;
    run_job(16'd7, 4'd5,  1'b0, 1'b0, '0);
    run_job(16'd7, 4'd15, 1'b0, 1'b0, '0);
    run_job(16'd7, 4'd0,  1'b0, 1'b0, '0);

    // random jobs at both latencies
    for (int i = 0; i < 10; i++) begin
      lat = (i % 2 == 0) ? 5 : $urandom_range(1, 4);
      rx  = W'($urandom_range(0, 12));
      re  = EW'($urandom_range(0, 15));
      run_job(rx, re, 1'b0, 1'b0, '0);
    end

    chk("operand_stability", 32'(stab_bad), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
